// File: rtl/ucaspian_synapse_walk.sv
// Synapse walker: expands an accepted [syn_start..syn_end] range into one dendrite event per synapse.
// Optional build macro SYN_SKIP_ZERO_EN drops zero-weight synapses instead of emitting them.
module ucaspian_synapse_walk (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear_config,
  output logic        clear_done,
  input  logic [11:0] config_addr,
  input  logic [15:0] config_value,
  input  logic        config_enable,
  input  logic [11:0] syn_start,
  input  logic [11:0] syn_end,
  input  logic        syn_vld,
  output logic        syn_rdy,
  output logic [7:0]  dend_addr,
  output logic [7:0]  dend_charge,
  output logic        dend_vld,
  input  logic        dend_rdy,
  output logic        idle
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_CLEAR} state_t;

  state_t      state_q, state_d;
  logic [11:0] cur_q, cur_d;
  logic [11:0] end_q, end_d;
  logic [11:0] clr_cnt_q, clr_cnt_d;
  logic        clear_done_q, clear_done_d;
  logic        idle_q, idle_d;
  logic        inflight_q, inflight_d;
  logic [15:0] fifo_q [2];
  logic [15:0] fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic [15:0] ram [4096];
  logic [15:0] ram_rd_q;
  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [15:0] ram_wdata;

  logic        rd_en, pop, push, byp_vld, fifo_nempty;
  logic [2:0]  occ_after_pop;

  // Write port: clear sweep owns it while in CLEAR, otherwise the config bus.
  always_comb begin
    ram_we    = config_enable;
    ram_waddr = config_addr;
    ram_wdata = config_value;
    if (state_q == S_CLEAR) begin
      ram_we    = clear_config;
      ram_waddr = clr_cnt_q;
      ram_wdata = 16'h0000;
    end
  end

  // Non-blocking read and write give read-old-data on a same-address collision.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    if (rd_en)  ram_rd_q <= ram[cur_q];
  end

  // The RAM output register acts as the entry ahead of the 2-deep FIFO so the
  // first event can appear two cycles after acceptance.
`ifdef SYN_SKIP_ZERO_EN
  assign byp_vld = inflight_q && (ram_rd_q[7:0] != 8'h00);
`else
  assign byp_vld = inflight_q;
`endif

  assign fifo_nempty = (count_q != 2'd0);
  assign dend_vld    = fifo_nempty || byp_vld;
  assign pop         = dend_vld && dend_rdy;
  assign push        = byp_vld && !(!fifo_nempty && pop);

  always_comb begin
    dend_addr   = fifo_q[rd_ptr_q][15:8];
    dend_charge = fifo_q[rd_ptr_q][7:0];
    if (!fifo_nempty && byp_vld) begin
      dend_addr   = ram_rd_q[15:8];
      dend_charge = ram_rd_q[7:0];
    end
  end

  assign occ_after_pop = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign rd_en   = (state_q == S_WALK) && !clear_config && (occ_after_pop < 3'd2);
  assign syn_rdy = reset_n && (state_q == S_IDLE) && enable && !clear_config;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    end_d     = end_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clear_config) begin
          state_d   = S_CLEAR;
          clr_cnt_d = 12'd0;
        end else if (syn_vld && syn_rdy) begin
          cur_d   = syn_start;
          end_d   = syn_end;
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        if (clear_config) begin
          state_d   = S_CLEAR;
          clr_cnt_d = 12'd0;
        end else if (rd_en) begin
          if (cur_q == end_q) state_d = S_IDLE;
          else                cur_d   = cur_q + 12'd1;
        end
      end
      S_CLEAR: begin
        if (!clear_config) begin
          state_d   = S_IDLE;
          clr_cnt_d = 12'd0;
        end else if (clr_cnt_q != 12'hFFF) begin
          clr_cnt_d = clr_cnt_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = rd_en;
    if (clear_config) begin
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = 2'd0;
      inflight_d = 1'b0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = ram_rd_q;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop && fifo_nempty) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop && fifo_nempty);
    end
  end

  assign clear_done_d = (state_q == S_CLEAR) && clear_config && (clr_cnt_q == 12'hFFF);
  assign idle_d       = (state_d == S_IDLE) && !inflight_d && (count_d == 2'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cur_q        <= 12'd0;
      end_q        <= 12'd0;
      clr_cnt_q    <= 12'd0;
      clear_done_q <= 1'b0;
      idle_q       <= 1'b1;
      inflight_q   <= 1'b0;
      fifo_q[0]    <= 16'h0000;
      fifo_q[1]    <= 16'h0000;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      end_q        <= end_d;
      clr_cnt_q    <= clr_cnt_d;
      clear_done_q <= clear_done_d;
      idle_q       <= idle_d;
      inflight_q   <= inflight_d;
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign clear_done = clear_done_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_ucaspian_synapse_walk.sv
// Scoreboard bench for ucaspian_synapse_walk; honours SYN_SKIP_ZERO_EN when defined.
module tb_ucaspian_synapse_walk;

`ifdef SYN_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b1, clear_config = 1'b0;
  logic        config_enable = 1'b0, syn_vld = 1'b0, dend_rdy = 1'b1;
  logic [11:0] config_addr = '0, syn_start = '0, syn_end = '0;
  logic [15:0] config_value = '0;
  logic        clear_done, syn_rdy, dend_vld, idle;
  logic [7:0]  dend_addr, dend_charge;

  ucaspian_synapse_walk dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear_config(clear_config),
    .clear_done(clear_done), .config_addr(config_addr), .config_value(config_value),
    .config_enable(config_enable), .syn_start(syn_start), .syn_end(syn_end),
    .syn_vld(syn_vld), .syn_rdy(syn_rdy), .dend_addr(dend_addr),
    .dend_charge(dend_charge), .dend_vld(dend_vld), .dend_rdy(dend_rdy), .idle(idle)
  );

  always #5 clk = ~clk;

  int          n_tests = 0, n_fail = 0, n_pop = 0, bp_i = 0;
  bit          bp_mode = 1'b0;
  logic [15:0] model [4096];
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Backpressure pattern 1,0,0,1,0 repeating when enabled.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      dend_rdy = (bp_i % 5 == 0) || (bp_i % 5 == 3);
      bp_i++;
    end else dend_rdy = 1'b1;
  end

  always @(negedge clk) begin : mon
    logic [15:0] e;
    if (reset_n && dend_vld && dend_rdy) begin
      n_pop++;
      if (exp_q.size() == 0) chk("extra_evt", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("evt", {16'h0, dend_addr, dend_charge}, {16'h0, e});
      end
    end
  end

  task automatic cfg(input logic [11:0] a, input logic [15:0] v);
    config_addr = a; config_value = v; config_enable = 1'b1;
    model[a] = v;
    @(posedge clk); #1;
    config_enable = 1'b0;
  endtask

  task automatic range(input logic [11:0] s, input logic [11:0] e);
    int n = 0;
    logic [11:0] a;
    while (!syn_rdy && n < 300) begin @(posedge clk); #1; n++; end
    if (!syn_rdy) chk("rdy_timeout", 32'd0, 32'd1);
    a = s;
    forever begin
      if (!(SKIP && model[a][7:0] == 8'h00)) exp_q.push_back(model[a]);
      if (a == e) break;
      a = a + 12'd1;
    end
    syn_start = s; syn_end = e; syn_vld = 1'b1;
    @(posedge clk); #1;
    syn_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 400) begin @(negedge clk); n++; end
    chk(tag, {31'd0, exp_q.size() == 0 && idle}, 32'd1);
  endtask

  initial begin
    int base, k;
    repeat (3) @(posedge clk); #1;
    chk("rst_syn_rdy", {31'd0, syn_rdy}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_dend_vld", {31'd0, dend_vld}, 32'd0);
    chk("rst_dend", {16'd0, dend_addr, dend_charge}, 32'd0);
    chk("rst_clear_done", {31'd0, clear_done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {31'd0, syn_rdy}, 32'd1);
    chk("post_rst_idle", {31'd0, idle}, 32'd1);
    @(posedge clk); #1;

    enable = 1'b0;
    #1 chk("en_low_rdy", {31'd0, syn_rdy}, 32'd0);
    enable = 1'b1;

    // Basic range with latency check
    cfg(12'h010, 16'h0305); cfg(12'h011, 16'h07FF);
    cfg(12'h012, 16'h0A80); cfg(12'h013, 16'h0101);
    base = n_pop;
    range(12'h010, 12'h013);
    chk("busy_idle", {31'd0, idle}, 32'd0);
    chk("lat_t1_vld", {31'd0, dend_vld}, 32'd0);
    @(posedge clk); #1;
    chk("lat_t2_vld", {31'd0, dend_vld}, 32'd1);
    chk("lat_t2_head", {16'd0, dend_addr, dend_charge}, 32'h0305);
    drain("basic_drain");
    chk("basic_cnt", n_pop - base, 32'd4);

    // Backpressure
    bp_mode = 1'b1;
    base = n_pop;
    range(12'h010, 12'h013);
    drain("bp_drain");
    chk("bp_cnt", n_pop - base, 32'd4);
    bp_mode = 1'b0;

    // Back-to-back ranges
    base = n_pop;
    range(12'h010, 12'h011);
    range(12'h012, 12'h013);
    drain("b2b_drain");
    chk("b2b_cnt", n_pop - base, 32'd4);

    // Wrap-around
    cfg(12'hFFE, 16'h1111); cfg(12'hFFF, 16'h2222);
    cfg(12'h000, 16'h33F3); cfg(12'h001, 16'h4404);
    base = n_pop;
    range(12'hFFE, 12'h001);
    drain("wrap_drain");
    chk("wrap_cnt", n_pop - base, 32'd4);
    chk("wrap_rdy", {31'd0, syn_rdy}, 32'd1);

    // Zero weight
    cfg(12'h020, 16'h0500); cfg(12'h021, 16'h0602);
    base = n_pop;
    range(12'h020, 12'h021);
    drain("zero_drain");
    chk("zero_cnt", n_pop - base, SKIP ? 32'd1 : 32'd2);

    // Clear mid-walk
    for (int i = 0; i < 256; i++) cfg(12'(i), {8'(i) ^ 8'h5A, 8'(i) | 8'h01});
    base = n_pop;
    range(12'h000, 12'h0FF);
    k = 0;
    while (n_pop < base + 10 && k < 300) begin @(posedge clk); k++; end
    #1;
    clear_config = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
      if (k == 1) begin
        chk("clr_vld_drop", {31'd0, dend_vld}, 32'd0);
        exp_q.delete();
      end
    end while (!clear_done && k < 5000);
    chk("clr_done_lat", k, 32'd4097);
    clear_config = 1'b0;
    for (int i = 0; i < 4096; i++) model[i] = 16'h0000;
    @(posedge clk); #1;
    chk("clr_done_low", {31'd0, clear_done}, 32'd0);
    base = n_pop;
    range(12'h000, 12'h003);
    drain("post_clr_drain");
    chk("post_clr_cnt", n_pop - base, SKIP ? 32'd0 : 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ucaspian_synapse_walk.md
# ucaspian_synapse_walk

Synapse-side responder for the axon→synapse range interface. Each accepted range `[syn_start..syn_end]` of 12-bit synapse ids is expanded into one dendrite event per synapse, at most one per cycle. Per-synapse target neuron and weight come from a 4096-entry synapse config RAM. The block sits between the axon stage and the dendrite/neuron charge accumulator.

## Interface
- No parameters; all widths fixed: 12-bit synapse id, 8-bit neuron id, 8-bit signed weight.
- `clk` in 1 — single clock; everything is posedge.
- `reset_n` in 1 — synchronous, active-low reset.
- `enable` in 1 — when low, no new range is accepted; a walk in progress completes.
- `clear_config` in 1 — level; zeroes the synapse RAM and aborts any walk.
- `clear_done` out 1 — registered; high while `clear_config` is high and all 4096 entries have been written.
- `config_addr` in 12 — synapse id to write.
- `config_value` in 16 — `[15:8]` target neuron, `[7:0]` signed weight.
- `config_enable` in 1 — writes `config_value` at `config_addr` in a single cycle.
- `syn_start` in 12 — first synapse id of the range.
- `syn_end` in 12 — last synapse id of the range (inclusive).
- `syn_vld` in 1 — range valid.
- `syn_rdy` out 1 — ready to accept a range.
- `dend_addr` out 8 — target neuron id.
- `dend_charge` out 8 — signed weight.
- `dend_vld` out 1 — dendrite event valid.
- `dend_rdy` in 1 — downstream ready.
- `idle` out 1 — registered; high when there is no walk, no read in flight, and the FIFO is empty.

## Operation
- The synapse RAM is 16×4096 and dual-port: one read port, one write port, 1-cycle read latency. A read and a write to the same address in the same cycle return the old data.
- FSM states:
  - IDLE: `syn_rdy` = 1 iff `enable && !clear_config`.
    - On `syn_vld && syn_rdy`: latch `cur` = `syn_start` and `end` = `syn_end`, go to WALK.
  - WALK: `syn_rdy` = 0. Issue RAM reads at `cur`.
    - After issuing the read at `cur == end`, go to IDLE.
    - Otherwise `cur` = `cur + 1` mod 4096.
  - CLEAR: entered from any state while `clear_config` = 1.
    - A 12-bit counter walks 0→4095, writing 0 at each address, then holds at 4095 and sets `clear_done`.
    - On `clear_config` deassertion: counter resets to 0, `clear_done` = 0, go to IDLE.
- Range wrap: `syn_end < syn_start` is legal. The walk wraps through 4095→0 and stops at `end`.
- Single-synapse ranges (`start == end`) emit exactly one event.
- Output buffering: 2-entry FIFO of `{addr, charge}`. `dend_vld` = FIFO non-empty; the head drives `dend_addr` and `dend_charge`.
- Read issue rule: `rd_en` = WALK && (`count + inflight − pop`) < 2, where `pop` = `dend_vld && dend_rdy`. Each read sets `inflight`; the returned data is pushed the next cycle.
- `config_enable` is honoured in any state except CLEAR. Entries already read keep their old values.

## Timing
- Reset values: `syn_rdy` 0, `dend_vld` 0, `dend_addr` 0, `dend_charge` 0, `clear_done` 0, `idle` 1; FSM in IDLE, FIFO empty, `inflight` 0.
- `syn_rdy` rises in the first cycle after reset deasserts, provided `enable` is high.
- Latency: range accepted in cycle t → first read in t+1 → first `dend_vld` in t+2.
- Throughput: 1 event/cycle while `dend_rdy` is held high.
- Backpressure: at most 2 reads outstanding beyond the FIFO head. Events are never dropped or reordered.
- `syn_rdy` returns in the cycle after the last read is issued. Events still draining from the FIFO do not block the next range.
- Clear mid-walk: in the cycle `clear_config` is seen, the FIFO is flushed, `inflight` is discarded, and `dend_vld` drops the next cycle.
- `clear_done` first rises 4097 cycles after `clear_config` first asserts.
- `reset_n` low mid-walk returns every register to its reset value on the next edge. RAM contents are not cleared by reset.

## Configuration
- `SYN_SKIP_ZERO_EN`:
  - Defined: returned entries with weight == 0 are not pushed into the FIFO. The read slot is consumed, but no event is emitted.
  - Undefined: every synapse in the range produces an event, including zero-weight synapses.

## Test plan
- Post-reset idle: release `reset_n` → `syn_rdy` = 1 next cycle, `idle` = 1, `dend_vld` = 0.
- Basic range: RAM[0x010..0x013] = {0x0305, 0x07FF, 0x0A80, 0x0101}; range 0x010–0x013 with `dend_rdy` = 1 → 4 back-to-back events (3,+5), (7,−1), (10,−128), (1,+1); first `dend_vld` 2 cycles after accept.
- Backpressure: same range, `dend_rdy` toggled 1,0,0,1,0,1… → same 4 events in order, none duplicated, and never more than 2 reads outstanding.
- Wrap-around: range 0xFFE–0x001 → events from addresses 0xFFE, 0xFFF, 0x000, 0x001, then `syn_rdy` = 1.
- Zero skip: RAM[0x020] = 0x0500, RAM[0x021] = 0x0602, range 0x020–0x021 → with `SYN_SKIP_ZERO_EN`, one event (6,+2); without it, two events (5,0), (6,+2).
- Clear mid-walk: start range 0x000–0x0FF, assert `clear_config` after 10 events → `dend_vld` low within 1 cycle, `clear_done` after 4097 cycles; a subsequent range 0x000–0x003 emits 4 events of (0,0).
